// File: rtl/tail_cmd_conditioner.sv
// Conditions the two raw tail-light switches into a committed {K1,K0} command with a change strobe.
// Path is 2-FF sync, per-bit debounce, then a settle window that absorbs skewed multi-bit transitions.
module tail_cmd_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SETTLE_CYCLES   = 2000000
) (
    input  logic       sys_clk_in,
    input  logic       sys_rst,
    input  logic [1:0] sw_raw,
    output logic [1:0] cmd_code,
    output logic       cmd_change,
    output logic [1:0] sw_stable
);

    localparam int CNT_MAX = (DEBOUNCE_CYCLES > SETTLE_CYCLES) ? DEBOUNCE_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    state_t           state_q;
    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic [CNT_W-1:0] dcnt_q [2];
    logic [CNT_W-1:0] dcnt_d [2];
    logic [1:0]       stable_q;
    logic [1:0]       stable_d;
    logic [1:0]       snap_q;
    logic [CNT_W-1:0] scnt_q;
    logic [1:0]       cmd_code_q;
    logic             cmd_change_q;

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 2; i++) begin
            dcnt_d[i] = dcnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                dcnt_d[i] = '0;
            end else if (dcnt_q[i] == DB_LAST) begin
                stable_d[i] = sync2_q[i];
                dcnt_d[i]   = '0;
            end else begin
                dcnt_d[i] = dcnt_q[i] + 1'b1;
            end
        end
    end

    // The settle FSM looks at the debounced value as it is being registered, so the
    // window opens on the same edge sw_stable moves and spans exactly SETTLE_CYCLES.
    always_ff @(posedge sys_clk_in) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            sync1_q      <= '0;
            sync2_q      <= '0;
            dcnt_q       <= '{default: '0};
            stable_q     <= '0;
            snap_q       <= '0;
            scnt_q       <= '0;
            cmd_code_q   <= '0;
            cmd_change_q <= 1'b0;
        end else begin
            sync1_q      <= sw_raw;
            sync2_q      <= sync1_q;
            dcnt_q       <= dcnt_d;
            stable_q     <= stable_d;
            cmd_change_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (stable_d != cmd_code_q) begin
                        state_q <= SETTLE;
                        scnt_q  <= '0;
                        snap_q  <= stable_d;
                    end
                end
                SETTLE: begin
                    if (stable_d == cmd_code_q) begin
                        state_q <= IDLE;
                        scnt_q  <= '0;
                    end else if (stable_d != snap_q) begin
                        snap_q <= stable_d;
                        scnt_q <= '0;
                    end else if (scnt_q == ST_LAST) begin
                        cmd_code_q   <= snap_q;
                        cmd_change_q <= 1'b1;
                        state_q      <= IDLE;
                        scnt_q       <= '0;
                    end else begin
                        scnt_q <= scnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    scnt_q  <= '0;
                end
            endcase
        end
    end

    assign cmd_code   = cmd_code_q;
    assign cmd_change = cmd_change_q;
    assign sw_stable  = stable_q;

endmodule

// File: tb/tb_tail_cmd_conditioner.sv
// Directed bench: short-window instance for latency/glitch/transit/reset cases,
// long-settle instance for the abort-to-origin case.
module tb_tail_cmd_conditioner;

    logic       clk;
    logic       rst;
    logic [1:0] raw;
    logic [1:0] cmd;
    logic       chg;
    logic [1:0] stable;
    logic [1:0] raw_l;
    logic [1:0] cmd_l;
    logic       chg_l;
    logic [1:0] stable_l;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int pulses_l = 0;
    int dbl = 0;
    logic prev_chg = 1'b0;
    logic [3:0] seen_cmd = '0;
    logic [3:0] seen_stable = '0;

    tail_cmd_conditioner #(.DEBOUNCE_CYCLES(4), .SETTLE_CYCLES(3)) u_dut (
        .sys_clk_in (clk),
        .sys_rst    (rst),
        .sw_raw     (raw),
        .cmd_code   (cmd),
        .cmd_change (chg),
        .sw_stable  (stable)
    );

    tail_cmd_conditioner #(.DEBOUNCE_CYCLES(4), .SETTLE_CYCLES(10)) u_dut_long (
        .sys_clk_in (clk),
        .sys_rst    (rst),
        .sw_raw     (raw_l),
        .cmd_code   (cmd_l),
        .cmd_change (chg_l),
        .sw_stable  (stable_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: inputs are driven at negedge, outputs sampled at the next negedge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        if (chg === 1'b1) pulses++;
        if (chg === 1'b1 && prev_chg) dbl++;
        prev_chg = chg;
        if (chg_l === 1'b1) pulses_l++;
        seen_cmd[cmd]       = 1'b1;
        seen_stable[stable] = 1'b1;
    endtask

    task automatic clr_watch();
        pulses      = 0;
        pulses_l    = 0;
        dbl         = 0;
        seen_cmd    = '0;
        seen_stable = '0;
    endtask

    // Checks the latency profile of a clean step from 'from' to 'to' over edges 1..10.
    task automatic step_profile(input string tag, input logic [1:0] from, input logic [1:0] to);
        for (int e = 1; e <= 10; e++) begin
            cyc();
            chk($sformatf("%s stable e%0d", tag, e), 32'(stable), 32'((e >= 6) ? to : from));
            chk($sformatf("%s cmd e%0d", tag, e), 32'(cmd), 32'((e >= 9) ? to : from));
            chk($sformatf("%s chg e%0d", tag, e), 32'(chg), 32'(e == 9));
        end
    endtask

    initial begin
        rst   = 1'b1;
        raw   = 2'b11;
        raw_l = 2'b00;
        @(negedge clk);

        // Reset held with switches high: outputs stay cleared.
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk("rst cmd", 32'(cmd), 32'h0);
            chk("rst stable", 32'(stable), 32'h0);
            chk("rst chg", 32'(chg), 32'h0);
        end
        rst = 1'b0;
        clr_watch();
        step_profile("post_rst", 2'b00, 2'b11);
        chk("post_rst pulses", 32'(pulses), 32'd1);

        // Return to off, then a clean 00->01 step.
        raw = 2'b00;
        for (int c = 0; c < 12; c++) cyc();
        chk("to_off cmd", 32'(cmd), 32'h0);
        clr_watch();
        raw = 2'b01;
        step_profile("clean", 2'b00, 2'b01);
        chk("clean pulses", 32'(pulses), 32'd1);

        // K1 glitch: 3-cycle pulse then single-cycle bounces; nothing may move.
        clr_watch();
        raw = 2'b11;
        for (int c = 0; c < 3; c++) cyc();
        for (int b = 0; b < 4; b++) begin
            raw = (b % 2 == 0) ? 2'b01 : 2'b11;
            cyc();
        end
        raw = 2'b01;
        for (int c = 0; c < 15; c++) cyc();
        chk("glitch pulses", 32'(pulses), 32'd0);
        chk("glitch seen_cmd", 32'(seen_cmd), 32'b0010);
        chk("glitch seen_stable", 32'(seen_stable), 32'b0010);

        // Skewed 01->10 through 11: commits 10 directly with one pulse.
        clr_watch();
        raw = 2'b11;
        cyc();
        raw = 2'b10;
        for (int c = 0; c < 15; c++) cyc();
        chk("transit cmd", 32'(cmd), 32'h2);
        chk("transit pulses", 32'(pulses), 32'd1);
        chk("transit no11", 32'(seen_cmd[3]), 32'd0);
        chk("transit dbl", 32'(dbl), 32'd0);

        // Reset while settling toward 11.
        clr_watch();
        raw = 2'b11;
        for (int c = 0; c < 6; c++) cyc();
        chk("midset stable", 32'(stable), 32'h3);
        chk("midset cmd", 32'(cmd), 32'h2);
        rst = 1'b1;
        cyc();
        chk("midset rst cmd", 32'(cmd), 32'h0);
        chk("midset rst chg", 32'(chg), 32'h0);
        chk("midset rst stable", 32'(stable), 32'h0);
        chk("midset rst pulses", 32'(pulses), 32'd0);
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) cyc();
        chk("midset e8 cmd", 32'(cmd), 32'h0);
        cyc();
        chk("midset e9 cmd", 32'(cmd), 32'h3);
        chk("midset e9 chg", 32'(chg), 32'h1);
        cyc();
        chk("midset e10 chg", 32'(chg), 32'h0);
        chk("midset pulses", 32'(pulses), 32'd1);

        // Abort to origin on the long-settle instance: commit 10, brief 11, back to 10.
        raw_l = 2'b10;
        for (int c = 0; c < 15; c++) cyc();
        chk("abort pre e15 cmd", 32'(cmd_l), 32'h0);
        cyc();
        chk("abort pre e16 cmd", 32'(cmd_l), 32'h2);
        for (int c = 0; c < 4; c++) cyc();
        clr_watch();
        raw_l = 2'b11;
        for (int c = 0; c < 6; c++) cyc();
        chk("abort stable11", 32'(stable_l), 32'h3);
        raw_l = 2'b10;
        for (int c = 0; c < 25; c++) cyc();
        chk("abort cmd", 32'(cmd_l), 32'h2);
        chk("abort stable", 32'(stable_l), 32'h2);
        chk("abort pulses", 32'(pulses_l), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
